// File: rtl/lhp_pkg.sv
// lhp_pkg: shared constants, FSM state type and branch decode
// for the local history branch predictor.
package lhp_pkg;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } lhp_state_e;

   function automatic logic is_cond_branch(
      input logic [31:0] instr
   );
      logic [5:0] op;
      logic [4:0] rt;
      op = instr[31:26];
      rt = instr[20:16];
      is_cond_branch = 1'b0;
      case (op)
         OP_BEQ, OP_BNE,
         OP_BLEZ, OP_BGTZ:
            is_cond_branch = 1'b1;
         OP_REGIMM:
            is_cond_branch = (rt == RT_BLTZ)
                          || (rt == RT_BGEZ)
                          || (rt == RT_BLTZAL)
                          || (rt == RT_BGEZAL);
         default:
            is_cond_branch = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter_update.sv
// sat_counter_update: next value of a CTR_W-bit saturating counter.
// Ports: ctr (current), up (1 = count up), ctr_next (result).
module sat_counter_update #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             up,
   output logic [CTR_W-1:0] ctr_next
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   always_comb begin
      ctr_next = ctr;
      if (up) begin
         if (ctr != CTR_MAX)
            ctr_next = ctr + 1'b1;
      end else begin
         if (ctr != '0)
            ctr_next = ctr - 1'b1;
      end
   end

endmodule

// File: rtl/local_history_predictor.sv
// local_history_predictor: two-level local predictor (per-PC BHT
// indexing a shared PHT of saturating counters) for MIPS fetch.
// Ports: CLK, RESET (sync, active high), FLUSH; lookup Instr_valid/
// Instr_input/Instr_addr_input -> Pred_valid/Taken one cycle later;
// update Update_valid/Update_addr/Update_taken; Ready after the
// table init sweep. Macro LHP_PERF_COUNTERS_EN adds
// Update_mispredict, Stat_lookups and Stat_mispredicts.
module local_history_predictor
   import lhp_pkg::*;
#(
   parameter int BHT_IDX_W = 10,
   parameter int HIST_W    = 10,
   parameter int CTR_W     = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
   input  logic        Instr_valid,
   input  logic [31:0] Instr_input,
   input  logic [31:0] Instr_addr_input,
   input  logic        Update_valid,
   input  logic [31:0] Update_addr,
   input  logic        Update_taken,
`ifdef LHP_PERF_COUNTERS_EN
   input  logic        Update_mispredict,
   output logic [31:0] Stat_lookups,
   output logic [31:0] Stat_mispredicts,
`endif
   output logic        Ready,
   output logic        Pred_valid,
   output logic        Taken
);

   localparam int BHT_DEPTH = 1 << BHT_IDX_W;
   localparam int PHT_DEPTH = 1 << HIST_W;
   localparam int MAX_W = (BHT_IDX_W > HIST_W) ? BHT_IDX_W : HIST_W;
   localparam int SW_W  = MAX_W + 1;

   localparam logic [SW_W-1:0] BHT_END = SW_W'(BHT_DEPTH);
   localparam logic [SW_W-1:0] PHT_END = SW_W'(PHT_DEPTH);
   localparam logic [SW_W-1:0] SWEEP_LAST =
      ((BHT_DEPTH > PHT_DEPTH) ? BHT_END : PHT_END) - 1'b1;
   // Weakly not-taken: highest value whose MSB is still 0.
   localparam logic [CTR_W-1:0] CTR_WNT =
      CTR_W'((1 << (CTR_W - 1)) - 1);

   logic [HIST_W-1:0] bht [BHT_DEPTH];
   logic [CTR_W-1:0]  pht [PHT_DEPTH];

   lhp_state_e      state;
   logic [SW_W-1:0] sweep;

   logic                 lookup;
   logic                 upd;
   logic                 init_we;
   logic                 lk_branch;
   logic [BHT_IDX_W-1:0] lk_idx;
   logic [HIST_W-1:0]    lk_hist;
   logic [CTR_W-1:0]     lk_ctr;
   logic [BHT_IDX_W-1:0] up_idx;
   logic [HIST_W-1:0]    up_hist;
   logic [HIST_W:0]      up_shift;
   logic [HIST_W-1:0]    up_hist_next;
   logic [CTR_W-1:0]     up_ctr;
   logic [CTR_W-1:0]     up_ctr_next;
   logic                 unused_bits;

   assign unused_bits = ^{Instr_input, Instr_addr_input, Update_addr};

   assign lookup    = Instr_valid & Ready & ~FLUSH;
   assign upd       = Update_valid & Ready;
   assign init_we   = (state == ST_INIT) & ~RESET;
   assign lk_branch = is_cond_branch(Instr_input);

   // Reads are combinational from the current table contents, so a
   // lookup colliding with an update sees the pre-update values.
   assign lk_idx  = Instr_addr_input[BHT_IDX_W+1:2];
   assign lk_hist = bht[lk_idx];
   assign lk_ctr  = pht[lk_hist];

   assign up_idx       = Update_addr[BHT_IDX_W+1:2];
   assign up_hist      = bht[up_idx];
   assign up_ctr       = pht[up_hist];
   assign up_shift     = {up_hist, Update_taken};
   assign up_hist_next = up_shift[HIST_W-1:0];

   sat_counter_update #(
      .CTR_W (CTR_W)
   ) u_sat (
      .ctr      (up_ctr),
      .up       (Update_taken),
      .ctr_next (up_ctr_next)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_INIT;
         sweep      <= '0;
         Ready      <= 1'b0;
         Pred_valid <= 1'b0;
         Taken      <= 1'b0;
      end else begin
         Pred_valid <= 1'b0;
         Taken      <= 1'b0;
         unique case (state)
            ST_INIT: begin
               if (sweep == SWEEP_LAST) begin
                  state <= ST_RUN;
                  Ready <= 1'b1;
               end else begin
                  sweep <= sweep + 1'b1;
               end
            end
            ST_RUN: begin
               if (lookup) begin
                  Pred_valid <= 1'b1;
                  Taken      <= lk_branch & lk_ctr[CTR_W-1];
               end
            end
         endcase
      end
   end

   // Tables carry no reset; the sweep initialises them instead.
   always_ff @(posedge CLK) begin
      if (init_we) begin
         if (sweep < BHT_END)
            bht[sweep[BHT_IDX_W-1:0]] <= '0;
         if (sweep < PHT_END)
            pht[sweep[HIST_W-1:0]] <= CTR_WNT;
      end else if (upd) begin
         bht[up_idx]  <= up_hist_next;
         pht[up_hist] <= up_ctr_next;
      end
   end

`ifdef LHP_PERF_COUNTERS_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Stat_lookups     <= '0;
         Stat_mispredicts <= '0;
      end else begin
         if (lookup && lk_branch && (Stat_lookups != '1))
            Stat_lookups <= Stat_lookups + 1'b1;
         if (upd && Update_mispredict && (Stat_mispredicts != '1))
            Stat_mispredicts <= Stat_mispredicts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_local_history_predictor.sv
// tb_local_history_predictor: directed bench for the local history
// predictor; default instance plus a CTR_W=3 instance.
module tb_local_history_predictor;

   localparam logic [31:0] BEQ  = 32'h1000_0000;
   localparam logic [31:0] BNE  = 32'h1400_0000;
   localparam logic [31:0] BGEZ = 32'h0401_0000;
   localparam logic [31:0] RIMB = 32'h0402_0000;
   localparam logic [31:0] NOP  = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_flush, a_iv, a_uv, a_ut;
   logic [31:0] a_instr, a_pc, a_uaddr;
   logic        a_ready, a_pv, a_tk;

   logic        b_rst, b_flush, b_iv, b_uv, b_ut;
   logic [31:0] b_instr, b_pc, b_uaddr;
   logic        b_ready, b_pv, b_tk;

   int n_checks = 0;
   int n_fail   = 0;
   int n;
   int ok;

   local_history_predictor u_a (
      .CLK              (clk),
      .RESET            (a_rst),
      .FLUSH            (a_flush),
      .Instr_valid      (a_iv),
      .Instr_input      (a_instr),
      .Instr_addr_input (a_pc),
      .Update_valid     (a_uv),
      .Update_addr      (a_uaddr),
      .Update_taken     (a_ut),
      .Ready            (a_ready),
      .Pred_valid       (a_pv),
      .Taken            (a_tk)
   );

   local_history_predictor #(
      .CTR_W (3)
   ) u_b (
      .CLK              (clk),
      .RESET            (b_rst),
      .FLUSH            (b_flush),
      .Instr_valid      (b_iv),
      .Instr_input      (b_instr),
      .Instr_addr_input (b_pc),
      .Update_valid     (b_uv),
      .Update_addr      (b_uaddr),
      .Update_taken     (b_ut),
      .Ready            (b_ready),
      .Pred_valid       (b_pv),
      .Taken            (b_tk)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_update(input logic [31:0] pc, input logic t);
      a_uv = 1'b1; a_uaddr = pc; a_ut = t;
      tick();
      a_uv = 1'b0;
   endtask

   task automatic a_lookup(input logic [31:0] pc,
                           input logic [31:0] ins);
      a_iv = 1'b1; a_pc = pc; a_instr = ins;
      tick();
      a_iv = 1'b0;
   endtask

   task automatic b_update(input logic [31:0] pc, input logic t);
      b_uv = 1'b1; b_uaddr = pc; b_ut = t;
      tick();
      b_uv = 1'b0;
   endtask

   task automatic b_lookup(input logic [31:0] pc,
                           input logic [31:0] ins);
      b_iv = 1'b1; b_pc = pc; b_instr = ins;
      tick();
      b_iv = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_uv = 1'b0;
      a_ut = 1'b0; a_instr = '0; a_pc = '0; a_uaddr = '0;
      b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_uv = 1'b0;
      b_ut = 1'b0; b_instr = '0; b_pc = '0; b_uaddr = '0;
      tick();
      tick();
      check("rst_ready", a_ready, 0);
      check("rst_pred_valid", a_pv, 0);
      check("rst_taken", a_tk, 0);
      check("rst_ready_b", b_ready, 0);

      // Lookups during the sweep are ignored; reset at index 500.
      a_rst = 1'b0; b_rst = 1'b0;
      a_iv = 1'b1; a_pc = 32'h400; a_instr = BEQ;
      repeat (500) tick();
      check("ready_mid_sweep", a_ready, 0);
      check("lookup_before_ready", a_pv, 0);
      a_iv = 1'b0;
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      n = 0;
      while (!a_ready && n < 3000) begin
         tick();
         n++;
      end
      check("sweep_len", n, 1024);
      check("ready_b", b_ready, 1);

      a_lookup(32'h400, BEQ);
      check("first_pv", a_pv, 1);
      check("first_taken", a_tk, 0);
      tick();
      check("idle_pv", a_pv, 0);

      repeat (4) a_update(32'h400, 1'b1);
      check("hist_0x100", u_a.bht[256], 32'h00F);
      check("pht_0", u_a.pht[0], 2);
      check("pht_1", u_a.pht[1], 2);
      check("pht_3", u_a.pht[3], 2);
      check("pht_7", u_a.pht[7], 2);
      a_lookup(32'h400, BEQ);
      check("lookup_hist_f", a_tk, 0);

      // Lookup and update together: lookup sees PHT[0xF]=1.
      a_iv = 1'b1; a_pc = 32'h400; a_instr = BEQ;
      a_uv = 1'b1; a_uaddr = 32'h400; a_ut = 1'b1;
      tick();
      a_iv = 1'b0; a_uv = 1'b0;
      check("rbw_taken", a_tk, 0);
      check("rbw_pht_f", u_a.pht[15], 2);
      check("rbw_hist", u_a.bht[256], 32'h01F);

      // All-ones history keeps its PHT entry fixed across taken updates.
      repeat (10) a_update(32'hC00, 1'b1);
      check("hist_all_ones", u_a.bht[768], 32'h3FF);
      a_iv = 1'b1; a_pc = 32'hC00; a_instr = BEQ;
      a_uv = 1'b1; a_uaddr = 32'hC00; a_ut = 1'b1;
      tick();
      a_iv = 1'b0; a_uv = 1'b0;
      check("rbw2_taken", a_tk, 0);
      a_lookup(32'hC00, BEQ);
      check("rbw2_next_taken", a_tk, 1);

      a_lookup(32'hC00, NOP);
      check("nop_pv", a_pv, 1);
      check("nop_taken", a_tk, 0);
      a_lookup(32'hC00, BGEZ);
      check("bgez_taken", a_tk, 1);
      a_lookup(32'hC00, RIMB);
      check("regimm_other", a_tk, 0);
      a_lookup(32'hC00, BNE);
      check("bne_taken", a_tk, 1);

      // Periodic T,N branch; steady state from step 12 onward.
      ok = 0;
      for (int k = 0; k < 80; k++) begin
         a_iv = 1'b1; a_pc = 32'h800; a_instr = BNE;
         a_uv = 1'b1; a_uaddr = 32'h800; a_ut = ((k % 2) == 0);
         tick();
         if (k >= 40 && a_pv && (a_tk == a_ut))
            ok++;
      end
      a_iv = 1'b0; a_uv = 1'b0;
      check("periodic_hits", ok, 40);

      // Flush kills the lookup; the same-cycle update still lands.
      a_flush = 1'b1;
      a_iv = 1'b1; a_pc = 32'hC00; a_instr = BNE;
      a_uv = 1'b1; a_uaddr = 32'h404; a_ut = 1'b1;
      tick();
      a_flush = 1'b0; a_iv = 1'b0; a_uv = 1'b0;
      check("flush_pv", a_pv, 0);
      check("flush_taken", a_tk, 0);
      check("flush_update", u_a.bht[257], 1);
      a_lookup(32'hC00, BNE);
      check("post_flush_taken", a_tk, 1);

      // CTR_W=3: five PCs share history 0x3FF.
      for (int p = 0; p < 5; p++)
         repeat (10) b_update(32'h10 + 32'(4 * p), 1'b1);
      check("b_hist", u_b.bht[4], 32'h3FF);
      check("b_pht_init", u_b.pht[1023], 3);
      repeat (8) b_update(32'h10, 1'b1);
      check("b_sat_hi", u_b.pht[1023], 7);
      b_lookup(32'h10, BEQ);
      check("b_taken_sat", b_tk, 1);
      b_update(32'h14, 1'b0);
      b_update(32'h18, 1'b0);
      b_update(32'h1C, 1'b0);
      check("b_pht_4", u_b.pht[1023], 4);
      b_lookup(32'h20, BEQ);
      check("b_taken_4", b_tk, 1);
      b_update(32'h20, 1'b0);
      check("b_pht_3", u_b.pht[1023], 3);
      b_lookup(32'h10, BEQ);
      check("b_taken_3", b_tk, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
